// File: rtl/multi_lane_spi_rx.sv
// Multi-lane SPI slave receiver: SCK/CS/MOSI are oversampled in synth_clk, LANES bits shift in per SCK rise.
// Last-beat pin to data_valid is SYNC_STAGES+3 clocks; a word arriving at a full FIFO is dropped and flags overflow.

module multi_lane_spi_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             in_rdy_o,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o,
  input  logic             out_rdy_i
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full, empty, wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign in_rdy_o  = ~full | out_rdy_i;
  assign out_vld_o = ~empty;
  assign out_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign wr_en = in_vld_i & in_rdy_o;
  assign rd_en = out_rdy_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_dat_i;
  end
endmodule

module multi_lane_spi_rx #(
  parameter int LANES       = 2,
  parameter int WORD_BITS   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 synth_clk,
  input  logic                 synth_rst_n,
  input  logic                 sck_in,
  input  logic                 cs_in,
  input  logic [LANES-1:0]     mosi_in,
  output logic [WORD_BITS-1:0] synth_data,
  output logic                 data_valid,
  input  logic                 read_data,
  output logic                 busy,
  output logic                 overflow,
  output logic                 frame_err,
  input  logic                 clear_err
);
  localparam int BEATS = WORD_BITS / LANES;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [LANES-1:0]       mosi_sync_q [SYNC_STAGES];
  logic                   sck_prev_q;
  logic                   busy_q;

  always_ff @(posedge synth_clk) begin
    if (!synth_rst_n) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) mosi_sync_q[i] <= '0;
      sck_prev_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sck_sync_q     <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
      cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
      mosi_sync_q[0] <= mosi_in;
      for (int i = 1; i < SYNC_STAGES; i++) mosi_sync_q[i] <= mosi_sync_q[i-1];
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      busy_q     <= ~cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic             sync_sck, cs_act, sck_rise, cs_rise, cs_fall;
  logic [LANES-1:0] sync_mosi;

  assign sync_sck  = sck_sync_q[SYNC_STAGES-1];
  assign sync_mosi = mosi_sync_q[SYNC_STAGES-1];
  assign cs_act    = ~cs_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sync_sck & ~sck_prev_q;
  assign cs_rise   = cs_act & ~busy_q;
  assign cs_fall   = ~cs_act & busy_q;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic                 wrap_q, wrap_d;
  logic                 push_q;
  logic [WORD_BITS-1:0] push_dat_q;
  logic                 ferr_set;

  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    wrap_d   = 1'b0;
    ferr_set = 1'b0;
    if (cs_rise) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (cs_fall) begin
      cnt_d    = '0;
      ferr_set = (cnt_q != '0);
    end else if (cs_act && sck_rise) begin
      shift_d = {shift_q[WORD_BITS-LANES-1:0], sync_mosi};
      if (cnt_q == LAST_BEAT) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Completed word is captured the cycle after the wrap and offered to the FIFO one cycle later.
  always_ff @(posedge synth_clk) begin
    if (!synth_rst_n) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      wrap_q     <= 1'b0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      wrap_q  <= wrap_d;
      push_q  <= wrap_q;
      if (wrap_q) push_dat_q <= shift_q;
    end
  end

  logic fifo_in_rdy;
  logic ovf_q, ovf_d, ferr_q, ferr_d;

  multi_lane_spi_rx_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (synth_clk),
    .rst_n_i   (synth_rst_n),
    .in_vld_i  (push_q),
    .in_dat_i  (push_dat_q),
    .in_rdy_o  (fifo_in_rdy),
    .out_vld_o (data_valid),
    .out_dat_o (synth_data),
    .out_rdy_i (read_data)
  );

  // A new error event in the same cycle as clear_err keeps the flag set.
  always_comb begin
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (clear_err) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (push_q && !fifo_in_rdy) ovf_d  = 1'b1;
    if (ferr_set)               ferr_d = 1'b1;
  end

  always_ff @(posedge synth_clk) begin
    if (!synth_rst_n) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
    end
  end

  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
endmodule
